// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Memory-side bus of the fetch/data port arbiter: a single outstanding
//   request held until a one-cycle acknowledge.
//
//   m_req   : request, held until m_ack
//   m_we    : write enable
//   m_addr  : word-aligned address
//   m_wstrb : byte-lane write strobes (0000 on reads)
//   m_wdata : lane-replicated store data
//   m_rdata : read data, valid with m_ack
//   m_ack   : single-cycle completion
//
//   master : the arbiter side (drives the request)
//   slave  : the memory / bus wrapper side (drives data and acknowledge)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface mem_port_arbiter_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (
        output m_req, m_we, m_addr, m_wstrb, m_wdata,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wstrb, m_wdata,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch port and the data (M-stage) port. One requester is granted at a
//   time; data normally wins, but after MAX_D_STREAK consecutive data grants
//   with a fetch waiting, one fetch grant is forced. Data accesses get byte /
//   half / word lane steering, load extension and misalignment detection.
//
//   Ports:
//     clk, rst          : clock (rising edge), asynchronous active-low reset
//     i_req/i_addr      : fetch request and word address
//     i_rdata/i_stall   : fetched instruction / fetch not yet complete
//     d_req/d_we/d_op   : data request, store select, {zero-ext, size[1:0]}
//     d_addr/d_wdata    : byte address, right-justified store data
//     d_rdata/d_stall   : extended load data / data access not yet complete
//     d_err             : one-cycle pulse on a misaligned access (no memory op)
//     mem               : memory bus (master modport)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [31:0]                i_addr,
    output logic [31:0]                i_rdata,
    output logic                       i_stall,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [2:0]                 d_op,
    input  logic [31:0]                d_addr,
    input  logic [31:0]                d_wdata,
    output logic [31:0]                d_rdata,
    output logic                       d_stall,
    output logic                       d_err,
    mem_port_arbiter_if.master         mem
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BUSY_I = 3'd1;
    localparam logic [2:0] S_BUSY_D = 3'd2;
    localparam logic [2:0] S_DONE_I = 3'd3;
    localparam logic [2:0] S_DONE_D = 3'd4;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [2:0]  state_q,   state_d;
    logic [3:0]  streak_q,  streak_d;
    logic        m_req_q,   m_req_d;
    logic        m_we_q,    m_we_d;
    logic [31:0] m_addr_q,  m_addr_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [2:0]  op_q,      op_d;
    logic [1:0]  lane_q,    lane_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q,   d_err_d;

    // ------------------------------------------------------------------
    // Request decode (data side)
    // ------------------------------------------------------------------
    logic        d_is_byte, d_is_half, d_is_word;
    logic        d_misaligned;
    logic [3:0]  d_strb;
    logic [31:0] d_wdata_rep;
    logic        force_i;

    assign d_is_byte    = (d_op[1:0] == 2'b00);
    assign d_is_half    = (d_op[1:0] == 2'b01);
    assign d_is_word    = d_op[1];              // 10 and reserved 11
    assign d_misaligned = (d_is_half & d_addr[0]) | (d_is_word & (|d_addr[1:0]));

    always_comb begin
        d_strb = 4'b1111;
        case (d_op[1:0])
            2'b00:   d_strb = 4'b0001 << d_addr[1:0];
            2'b01:   d_strb = d_addr[1] ? 4'b1100 : 4'b0011;
            default: d_strb = 4'b1111;
        endcase
    end

    // Every lane carries the low byte (byte), the matching half (half) or
    // its own byte (word), so the memory can pick lanes by strobe alone.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign d_wdata_rep[8*gi +: 8] = d_is_byte ? d_wdata[7:0]
                                      : d_is_half ? d_wdata[8*(gi%2) +: 8]
                                      :             d_wdata[8*gi +: 8];
    end

    assign force_i = i_req & (streak_q == STREAK_MAX);

    // ------------------------------------------------------------------
    // Load lane extraction, using the op/lane latched at grant so a
    // requester that changes its inputs mid-flight cannot corrupt it.
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign ld_byte = 8'(mem.m_rdata >> {lane_q, 3'b000});
    assign ld_half = 16'(mem.m_rdata >> {lane_q[1], 4'b0000});

    always_comb begin
        ld_ext = mem.m_rdata;
        case (op_q[1:0])
            2'b00:   ld_ext = {{24{~op_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~op_q[2] & ld_half[15]}}, ld_half};
            default: ld_ext = mem.m_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wstrb_d = m_wstrb_q;
        m_wdata_d = m_wdata_q;
        op_d      = op_q;
        lane_d    = lane_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        d_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req && !force_i) begin
                    if (i_req && streak_q != 4'hF) begin
                        streak_d = streak_q + 4'd1;
                    end
                    op_d   = d_op;
                    lane_d = d_addr[1:0];
                    if (d_misaligned) begin
                        // Complete immediately with an error, memory untouched.
                        state_d   = S_DONE_D;
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'h0;
                    end else begin
                        state_d   = S_BUSY_D;
                        m_req_d   = 1'b1;
                        m_we_d    = d_we;
                        m_addr_d  = {d_addr[31:2], 2'b00};
                        m_wstrb_d = d_we ? d_strb : 4'b0000;
                        m_wdata_d = d_wdata_rep;
                    end
                end else if (i_req) begin
                    state_d   = S_BUSY_I;
                    streak_d  = 4'd0;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = {i_addr[31:2], 2'b00};
                    m_wstrb_d = 4'b0000;
                end
            end
            S_BUSY_I: begin
                if (mem.m_ack) begin
                    state_d   = S_DONE_I;
                    i_rdata_d = mem.m_rdata;
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    m_wstrb_d = 4'b0000;
                end
            end
            S_BUSY_D: begin
                if (mem.m_ack) begin
                    state_d = S_DONE_D;
                    if (!m_we_q) begin
                        d_rdata_d = ld_ext;
                    end
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    m_wstrb_d = 4'b0000;
                end
            end
            S_DONE_I, S_DONE_D: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The streak only measures how long a waiting fetch has been passed over.
        if (!i_req) begin
            streak_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            streak_q  <= 4'd0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'h0;
            m_wstrb_q <= 4'b0000;
            m_wdata_q <= 32'h0;
            op_q      <= 3'b000;
            lane_q    <= 2'b00;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wstrb_q <= m_wstrb_d;
            m_wdata_q <= m_wdata_d;
            op_q      <= op_d;
            lane_q    <= lane_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem.m_req   = m_req_q;
    assign mem.m_we    = m_we_q;
    assign mem.m_addr  = m_addr_q;
    assign mem.m_wstrb = m_wstrb_q;
    assign mem.m_wdata = m_wdata_q;

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign d_err   = d_err_q;
    assign i_stall = i_req & (state_q != S_DONE_I);
    assign d_stall = d_req & (state_q != S_DONE_D);

    // Fetch addresses are word accesses; the low bits are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MAX_D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_op = 3'b000;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        d_err;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_stall (i_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_op    (d_op),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_stall (d_stall),
        .d_err   (d_err),
        .mem     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference helpers: access arithmetic in terms of byte counts
    // ------------------------------------------------------------------
    function automatic int nbytes(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] op, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(op)) != 0;
    endfunction

    function automatic logic [3:0] strobes(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] s;
        int n, first;
        s = 4'b0000;
        n = nbytes(op);
        first = (int'(a[1:0]) / n) * n;
        for (int k = 0; k < n; k++) s[first + k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] w);
        logic [31:0] r;
        int n;
        n = nbytes(op);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] word);
        int unsigned v;
        int bits;
        if (op[1:0] == 2'b00) begin
            v = (word >> (8 * int'(a))) & 32'hFF;
            bits = 8;
        end else if (op[1:0] == 2'b01) begin
            v = (word >> (16 * int'(a[1]))) & 32'hFFFF;
            bits = 16;
        end else begin
            return word;
        end
        if (!op[2] && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 = free, 1 = memory op outstanding,
    // 2 = result cycle for mdl_port (1 = fetch, 2 = data).
    // ------------------------------------------------------------------
    int          mdl_phase = 0;
    int          mdl_port  = 0;
    bit          mdl_err   = 1'b0;
    int          streak    = 0;
    logic [31:0] exp_addr  = 32'h0;
    bit          exp_we    = 1'b0;
    logic [3:0]  exp_strb  = 4'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [2:0]  g_op      = 3'b0;
    logic [1:0]  g_lane    = 2'b0;
    logic [31:0] exp_i_rdata = 32'h0;
    logic [31:0] exp_d_rdata = 32'h0;
    int          txn_count = 0;
    bit          i_done_flag = 1'b0;
    bit          d_done_flag = 1'b0;
    bit          s_i_stall, s_d_stall;

    task automatic model_reset();
        mdl_phase = 0; mdl_port = 0; mdl_err = 1'b0; streak = 0;
        exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    endtask

    task automatic report(input string who);
        txn_count++;
        $display("txn %0d %s addr=%h we=%0d op=%0d i_rdata=%h d_rdata=%h err=%0d",
                 txn_count, who, (mdl_port == 1) ? i_addr : d_addr, exp_we, g_op,
                 exp_i_rdata, exp_d_rdata, mdl_err);
    endtask

    task automatic model_step();
        bit done_i, done_d, force_i;
        done_i = (mdl_phase == 2) && (mdl_port == 1);
        done_d = (mdl_phase == 2) && (mdl_port == 2);
        s_i_stall = i_stall;
        s_d_stall = d_stall;
        check("i_stall", 32'(i_stall), 32'(i_req && !done_i));
        check("d_stall", 32'(d_stall), 32'(d_req && !done_d));
        check("d_err",   32'(d_err),   32'(done_d && mdl_err));
        check("m_req",   32'(bus.m_req), 32'(mdl_phase == 1));
        check("i_rdata", i_rdata, exp_i_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        if (mdl_phase == 1) begin
            check("m_addr",  bus.m_addr, exp_addr);
            check("m_we",    32'(bus.m_we), 32'(exp_we));
            check("m_wstrb", 32'(bus.m_wstrb), 32'(exp_strb));
            if (exp_we) check("m_wdata", bus.m_wdata, exp_wdata);
        end
        if (!rst) begin
            check("rst_m_wstrb", 32'(bus.m_wstrb), 32'h0);
            check("rst_m_we",    32'(bus.m_we), 32'h0);
            model_reset();
            return;
        end
        case (mdl_phase)
            2: begin
                if (mdl_port == 1) i_done_flag = 1'b1; else d_done_flag = 1'b1;
                mdl_phase = 0;
            end
            1: begin
                if (bus.m_ack) begin
                    if (mdl_port == 1) exp_i_rdata = bus.m_rdata;
                    else if (!exp_we) exp_d_rdata = load_value(g_op, g_lane, bus.m_rdata);
                    mdl_phase = 2;
                    report((mdl_port == 1) ? "FETCH" : "DATA");
                end
            end
            default: begin
                force_i = i_req && (streak == MAX_D);
                if (d_req && !force_i) begin
                    if (i_req && streak < 15) streak++;
                    mdl_port = 2; g_op = d_op; g_lane = d_addr[1:0];
                    if (is_misaligned(d_op, d_addr)) begin
                        mdl_phase = 2; mdl_err = 1'b1; exp_we = 1'b0; exp_d_rdata = 32'h0;
                        report("DATA_MISALIGNED");
                    end else begin
                        mdl_phase = 1; mdl_err = 1'b0;
                        exp_addr  = d_addr & ~32'd3;
                        exp_we    = d_we;
                        exp_strb  = d_we ? strobes(d_op, d_addr) : 4'b0000;
                        exp_wdata = lane_wdata(d_op, d_wdata);
                    end
                end else if (i_req) begin
                    streak = 0;
                    mdl_port = 1; mdl_phase = 1; mdl_err = 1'b0;
                    exp_addr = i_addr & ~32'd3; exp_we = 1'b0; exp_strb = 4'b0000;
                end
            end
        endcase
        if (!i_req) streak = 0;
    endtask

    // ------------------------------------------------------------------
    // Memory responder and requester drivers
    // ------------------------------------------------------------------
    int          mem_cnt = -1;
    int          mem_wait_fixed = 0;
    bit          forced_valid = 1'b0;
    logic [31:0] forced_rdata = 32'h0;
    bit          spurious_en = 1'b0;
    bit          auto_mode = 1'b0;
    bit          prev_m_req = 1'b0;
    int          mreq_rises = 0;
    bit          log_en = 1'b0;
    int          n_grants = 0;
    logic [9:0]  grant_bits = 10'h0;

    initial begin
        bus.m_ack = 1'b0;
        bus.m_rdata = 32'h0;
    end

    task automatic mem_drive();
        if (bus.m_req) begin
            if (mem_cnt == -1) mem_cnt = (mem_wait_fixed >= 0) ? mem_wait_fixed : $urandom_range(0, 3);
            if (mem_cnt == 0) begin
                bus.m_ack = 1'b1;
                bus.m_rdata = forced_valid ? forced_rdata : $urandom;
                mem_cnt = -2;
            end else begin
                if (mem_cnt > 0) mem_cnt--;
                bus.m_ack = 1'b0;
            end
        end else begin
            mem_cnt = -1;
            bus.m_ack = spurious_en && ($urandom_range(0, 9) == 0);
            bus.m_rdata = $urandom;
        end
    endtask

    task automatic drive_requesters();
        bit d_inflight, i_inflight;
        d_inflight = (mdl_phase != 0) && (mdl_port == 2);
        i_inflight = (mdl_phase != 0) && (mdl_port == 1);
        if (d_req && !d_done_flag && $urandom_range(0, 49) == 0) begin
            d_req = 1'b0;
        end else if ((d_done_flag || !d_req) && !d_inflight) begin
            d_req = ($urandom_range(0, 99) < 60);
            if (d_req) begin
                d_addr  = $urandom;
                d_op    = 3'($urandom_range(0, 7));
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
            end
        end
        if (i_req && !i_done_flag && $urandom_range(0, 49) == 0) begin
            i_req = 1'b0;
        end else if ((i_done_flag || !i_req) && !i_inflight) begin
            i_req = ($urandom_range(0, 99) < 60);
            if (i_req) i_addr = $urandom;
        end
        d_done_flag = 1'b0;
        i_done_flag = 1'b0;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic run_cycle();
        if (auto_mode) drive_requesters();
        mem_drive();
        #1;
        model_step();
        if (bus.m_req && !prev_m_req) begin
            mreq_rises++;
            if (log_en && n_grants < 10) begin
                grant_bits[n_grants] = (bus.m_addr == {i_addr[31:2], 2'b00});
                n_grants++;
            end
        end
        prev_m_req = bus.m_req;
        @(negedge clk);
    endtask

    task automatic wait_port(input bit is_d, input int budget, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < budget) begin
            run_cycle();
            n++;
            got = is_d ? !s_d_stall : !s_i_stall;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout port=%0d cycles=%0d", is_d, n);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n, rises0;
        @(negedge clk);
        repeat (3) run_cycle();

        // Reset fetch vector, one memory wait cycle.
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'hBFC00000;
        mem_wait_fixed = 1; forced_valid = 1'b1; forced_rdata = 32'h3C010001;
        wait_port(1'b0, 20, n);
        check("fetch_latency", 32'(n), 32'd4);
        check("fetch_rdata", i_rdata, 32'h3C010001);
        i_req = 1'b0;
        repeat (2) run_cycle();

        // LB / LBU from lane 3, zero-wait memory.
        mem_wait_fixed = 0; forced_rdata = 32'h80FFFF7F;
        d_req = 1'b1; d_we = 1'b0; d_op = 3'b000; d_addr = 32'h00001003;
        wait_port(1'b1, 20, n);
        check("lb_latency", 32'(n), 32'd3);
        check("lb_rdata", d_rdata, 32'hFFFFFF80);
        d_req = 1'b0;
        run_cycle();
        d_req = 1'b1; d_op = 3'b100;
        wait_port(1'b1, 20, n);
        check("lbu_rdata", d_rdata, 32'h00000080);
        d_req = 1'b0;
        run_cycle();

        // SH to the upper half.
        d_req = 1'b1; d_we = 1'b1; d_op = 3'b001; d_addr = 32'h00002002; d_wdata = 32'h0000BEEF;
        run_cycle();
        check("sh_wstrb", 32'(bus.m_wstrb), 32'hC);
        check("sh_wdata", bus.m_wdata, 32'hBEEFBEEF);
        check("sh_we", 32'(bus.m_we), 32'h1);
        wait_port(1'b1, 20, n);
        check("sh_latency", 32'(n), 32'd2);
        d_req = 1'b0;
        run_cycle();

        // Misaligned LW: no memory op, immediate error completion.
        rises0 = mreq_rises;
        d_req = 1'b1; d_we = 1'b0; d_op = 3'b010; d_addr = 32'h00002001;
        wait_port(1'b1, 20, n);
        check("lw_mis_latency", 32'(n), 32'd2);
        check("lw_mis_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        repeat (2) run_cycle();
        check("lw_mis_no_mreq", 32'(mreq_rises - rises0), 32'd0);

        // Both ports held, zero-wait memory: fairness after MAX_D data grants.
        i_req = 1'b1; i_addr = 32'h00400000;
        d_req = 1'b1; d_op = 3'b010; d_addr = 32'h10000000;
        forced_valid = 1'b0;
        n_grants = 0; grant_bits = 10'h0; log_en = 1'b1;
        for (int k = 0; k < 200 && n_grants < 10; k++) run_cycle();
        log_en = 1'b0;
        check("grant_count", 32'(n_grants), 32'd10);
        check("grant_order", 32'(grant_bits), 32'h210);
        i_req = 1'b0; d_req = 1'b0;
        repeat (6) run_cycle();

        // Asynchronous reset with a data op outstanding.
        mem_wait_fixed = 10;
        i_req = 1'b1; i_addr = 32'h00500000;
        d_req = 1'b1; d_addr = 32'h00003000;
        for (int k = 0; k < 10 && !prev_m_req; k++) run_cycle();
        check("busy_before_reset", 32'(bus.m_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_m_req", 32'(bus.m_req), 32'h0);
        check("async_m_wstrb", 32'(bus.m_wstrb), 32'h0);
        check("async_d_rdata", d_rdata, 32'h0);
        model_reset();
        mem_cnt = -1;
        prev_m_req = 1'b0;
        @(negedge clk);
        run_cycle();
        rst = 1'b1;
        mem_wait_fixed = 0;
        n_grants = 0; grant_bits = 10'h0; log_en = 1'b1;
        wait_port(1'b1, 20, n);
        log_en = 1'b0;
        check("post_reset_latency", 32'(n), 32'd3);
        check("post_reset_grants", 32'(n_grants), 32'd1);
        check("post_reset_is_data", 32'(grant_bits[0]), 32'h0);
        i_req = 1'b0; d_req = 1'b0;
        repeat (6) run_cycle();

        // Randomized traffic: random waits, spurious acks, dropped requests.
        mem_wait_fixed = -1; spurious_en = 1'b1; auto_mode = 1'b1;
        repeat (3000) run_cycle();
        auto_mode = 1'b0; spurious_en = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        repeat (10) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
